adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit ripple-carry adder among NREQ requesters. Each requester presents operands a, b and carry-in under a valid/ready handshake. The block registers the winning operands, lets the adder settle for one full cycle, and returns the WIDTH+1-bit carry-out/sum tagged with the requester index on a single response channel. It sits between the requesting datapath units and the shared adder instance.

---
 rtl/adder_arb_pkg.sv | 40 ++++
 rtl/adder_arbiter_if.sv | 32 +++
 rtl/adder_structure.sv | 25 ++
 rtl/adder_arbiter.sv | 98 +++++++++
 tb/tb_adder_arbiter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder arbiter.
//   state_e  : sequencer states (IDLE, CALC, RESP)
//   pick_t   : round-robin pick result (found flag + winning index)
//   rr_pick  : round-robin search from ptr upward with wrap
package adder_arb_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREQ_DEF  = 4;
    // Upper bound on requesters the pick helper can scan.
    localparam int MAX_NREQ  = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_e;

    typedef struct packed {
        logic       found;
        logic [7:0] idx;
    } pick_t;

    // First i at or after ptr (mod nreq) with valid[i] set.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                      input int ptr, input int nreq);
        pick_t r;
        int    i;
        r = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            i = ptr + k;
            if (i >= nreq) i = i - nreq;
            if (k < nreq && !r.found && valid[i]) begin
                r.found = 1'b1;
                r.idx   = 8'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between requesters and the shared adder.
//   req_valid/req_ready : per-requester handshake (NREQ bits)
//   req_a/req_b         : flat operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin             : per-requester carry-in
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_sum      : owner index and {carry_out, sum}
// slave = arbiter side, master = requester/consumer side.
interface adder_arbiter_if #(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH:0]        rsp_sum;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/adder_structure.sv
// Structural ripple-carry adder.
//   a, b  : operands (WIDTH)
//   c_in  : carry-in
//   sum   : WIDTH-bit sum
//   c_out : carry out of the top bit
module adder_structure #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    logic [WIDTH:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[WIDTH];
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one ripple-carry adder among NREQ
// requesters. Accept in IDLE, let the adder settle on registered operands
// for one CALC cycle, then hold the result in RESP until it is taken.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : adder_arbiter_if.slave (requests in, response out)
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int NREQ  = NREQ_DEF,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_arbiter_if.slave   bus
);
    state_e              state, state_nxt;
    logic [IDW-1:0]      ptr;
    logic [WIDTH-1:0]    op_a, op_b;
    logic                op_cin;
    logic [IDW-1:0]      op_id;
    logic [WIDTH:0]      sum_q;
    logic [IDW-1:0]      id_q;

    logic [MAX_NREQ-1:0] vpad;
    pick_t               pick;
    logic                pick_ok;
    logic [IDW-1:0]      pick_id;
    logic                accept;

    logic [WIDTH-1:0]    add_sum;
    logic                add_cout;

    always_comb begin
        vpad             = '0;
        vpad[NREQ-1:0]   = bus.req_valid;
    end

    assign pick    = rr_pick(vpad, int'(ptr), NREQ);
    assign pick_ok = pick.found && (int'(pick.idx) < NREQ);
    assign pick_id = IDW'(pick.idx);
    // Grants are suppressed while reset is asserted.
    assign accept  = rst_n && (state == IDLE) && pick_ok;

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: if (accept) begin
                bus.req_ready[pick_id] = 1'b1;
                state_nxt              = CALC;
            end
            CALC: state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    adder_structure #(.WIDTH(WIDTH)) u_add (
        .a     (op_a),
        .b     (op_b),
        .c_in  (op_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
            op_id  <= '0;
            sum_q  <= '0;
            id_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a   <= bus.req_a[int'(pick_id)*WIDTH +: WIDTH];
                op_b   <= bus.req_b[int'(pick_id)*WIDTH +: WIDTH];
                op_cin <= bus.req_cin[pick_id];
                op_id  <= pick_id;
                ptr    <= (pick_id == IDW'(NREQ-1)) ? '0 : pick_id + 1'b1;
            end
            // Adder has had the whole CALC cycle to ripple.
            if (state == CALC) begin
                sum_q <= {add_cout, add_sum};
                id_q  <= op_id;
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_id    = id_q;
endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
    adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [32:0] exp;
    } vec_t;
    vec_t vt [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
        bus.req_cin[id]      = cin;
    endtask

    // One transaction from a single requester; starts in IDLE, ends in IDLE at T+3.
    task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic [32:0] exp);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        bus.req_valid     = '0;
        drive(id, a, b, cin);
        bus.req_valid[id] = 1'b1;
        bus.rsp_ready     = 1'b1;
        #1;
        check("grant", 64'(bus.req_ready), 64'(oh));
        tick();
        // Operands change after the handshake must not leak into the result.
        bus.req_valid = '0;
        drive(id, ~a, ~b, ~cin);
        #1;
        check("calc_ready", 64'(bus.req_ready), 64'd0);
        check("calc_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("rsp_sum", 64'(bus.rsp_sum), 64'(exp));
        check("rsp_id", 64'(bus.rsp_id), 64'(id));
        tick();
        check("back_idle", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] e;
        logic [3:0]  oh;
        int          g;

        vt[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000};
        vt[1] = '{2, 32'd5,         32'd7,         1'b1, 33'd13};
        vt[2] = '{0, 32'h0,         32'h0,         1'b0, 33'h0};
        vt[3] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
        vt[4] = '{3, 32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789};
        vt[5] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0001};

        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 32'hFFFF_FFF0 + 32'(i), 32'(i * 3), 1'(i & 1));

        // Reset held 3 cycles with every requester valid.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_valid", 64'(bus.rsp_valid), 64'd0);
            check("rst_sum", 64'(bus.rsp_sum), 64'd0);
            check("rst_ready", 64'(bus.req_ready), 64'd0);
        end
        rst_n = 1'b1;
        #1;

        // Round robin: 0,1,2,3,0, three cycles apart.
        for (g = 0; g < 5; g++) begin
            int id;
            id = g % N;
            oh = 4'b0001 << id;
            e  = {1'b0, 32'hFFFF_FFF0 + 32'(id)} + 33'(id * 3) + 33'(id & 1);
            check("rr_grant", 64'(bus.req_ready), 64'(oh));
            tick();
            check("rr_calc_ready", 64'(bus.req_ready), 64'd0);
            check("rr_calc_valid", 64'(bus.rsp_valid), 64'd0);
            tick();
            check("rr_valid", 64'(bus.rsp_valid), 64'd1);
            check("rr_id", 64'(bus.rsp_id), 64'(id));
            check("rr_sum", 64'(bus.rsp_sum), 64'(e));
            check("rr_resp_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end

        // Backpressure: requester 3 only, then hold RESP for 5 cycles.
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b0;
        drive(3, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
        #1;
        check("bp_grant", 64'(bus.req_ready), 64'b1000);
        tick();
        bus.req_valid = '1;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_sum", 64'(bus.rsp_sum), 64'h0_EFBE_D000);
            check("bp_id", 64'(bus.rsp_id), 64'd3);
            check("bp_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_valid", 64'(bus.rsp_valid), 64'd1);
        tick();
        check("bp_idle_valid", 64'(bus.rsp_valid), 64'd0);
        check("bp_wrap_grant", 64'(bus.req_ready), 64'b0001);
        bus.req_valid = '0;
        #1;

        // Directed arithmetic vectors.
        for (int i = 0; i < 6; i++) run_one(vt[i].id, vt[i].a, vt[i].b, vt[i].cin, vt[i].exp);

        // Reset during CALC: response dropped, ptr back to 0.
        bus.req_valid = 4'b0010;
        drive(1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        #1;
        check("mid_grant", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = '0;
        rst_n         = 1'b0;
        tick();
        check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_sum", 64'(bus.rsp_sum), 64'd0);
        check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        tick();
        check("mid_rst_valid2", 64'(bus.rsp_valid), 64'd0);
        rst_n         = 1'b1;
        bus.req_valid = '1;
        #1;
        check("mid_ptr0", 64'(bus.req_ready), 64'b0001);
        check("mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
        bus.req_valid = '0;
        #1;

        // Served normally after reset; leaves ptr at 3.
        run_one(2, 32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h100);
        // ptr=3, only requester 1 valid: skip 3 and 0, grant 1.
        run_one(1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 33'h0_8000_0000);
        bus.req_valid = '1;
        #1;
        check("skip_ptr2", 64'(bus.req_ready), 64'b0100);
        bus.req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
